// File: rtl/dds_gen_sequencer.sv
// Burst sequencer for the DDS phase accumulators: validates a command, holds the parameter bus, runs packets.
// Optional one-entry shadow command register enabled by DDS_SEQ_SHADOW_CMD_EN.
module dds_gen_sequencer #(
  parameter int START_TMO = 64,
  parameter int GAP_W     = 16,
  parameter int REP_W     = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_SIGNAL_TYPE,
  input  logic [31:0]      CMD_F_CARRIER,
  input  logic [9:0]       CMD_T_IMPULSE,
  input  logic [12:0]      CMD_T_PERIOD,
  input  logic [4:0]       CMD_NUM_OF_IMP,
  input  logic [21:0]      CMD_DEVIATION,
  input  logic [REP_W-1:0] CMD_REPEAT,
  input  logic [GAP_W-1:0] CMD_GAP,
  input  logic             ABORT,
  input  logic             OUT_REG_READY,
  input  logic             SIGN_START_CALC,
  input  logic             SIGN_STOP_CALC,
  output logic [1:0]       SIGNAL_TYPE,
  output logic [31:0]      F_CARRIER,
  output logic [9:0]       T_IMPULSE,
  output logic [12:0]      T_PERIOD,
  output logic [4:0]       NUM_OF_IMP,
  output logic [21:0]      DEVIATION,
  output logic             SIGN_START_GEN,
  output logic             ACC_RESET,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERROR,
  output logic [1:0]       ERR_CODE,
  output logic [REP_W-1:0] PKT_CNT
);

  typedef enum logic [2:0] {IDLE, ARM, START, RUN, GAP} state_t;

  localparam int B  = GAP_W + REP_W;
  localparam int CW = B + 84;
  localparam int TW = $clog2(START_TMO + 1);

  state_t           r_state, w_nxt_state;
  logic [CW-1:0]    r_cmd, w_nxt_cmd, w_cmd;
  logic             r_live, r_sgen, w_nxt_sgen;
  logic             r_accrst, w_nxt_accrst;
  logic             r_done, w_nxt_done;
  logic             r_err, w_nxt_err;
  logic [1:0]       r_ecode, w_nxt_ecode;
  logic [REP_W-1:0] r_pkt, w_nxt_pkt, w_pkt1, w_rep;
  logic [TW-1:0]    r_tmo, w_nxt_tmo;
  logic [GAP_W-1:0] r_gcnt, w_nxt_gcnt, w_gap, w_gap_ld;
  logic             w_acc, w_bad, w_last;
`ifdef DDS_SEQ_SHADOW_CMD_EN
  logic             r_sh_v, w_nxt_sh_v;
  logic [CW-1:0]    r_sh, w_nxt_sh;
`endif

  assign w_cmd = {CMD_SIGNAL_TYPE, CMD_F_CARRIER, CMD_T_IMPULSE, CMD_T_PERIOD,
                  CMD_NUM_OF_IMP, CMD_DEVIATION, CMD_REPEAT, CMD_GAP};
  assign w_bad = (CMD_NUM_OF_IMP == 5'd0) || (CMD_T_IMPULSE == 10'd0) ||
                 ((CMD_NUM_OF_IMP > 5'd1) && ({3'b000, CMD_T_IMPULSE} > CMD_T_PERIOD));

`ifdef DDS_SEQ_SHADOW_CMD_EN
  assign CMD_READY = r_live && ((r_state == IDLE) || !r_sh_v);
`else
  assign CMD_READY = r_live && (r_state == IDLE);
`endif
  assign w_acc = CMD_VALID && CMD_READY;

  assign w_rep    = r_cmd[GAP_W +: REP_W];
  assign w_gap    = r_cmd[GAP_W-1:0];
  // Gap of at least 2 lets the accumulator drop its busy flag first
  assign w_gap_ld = (w_gap < GAP_W'(2)) ? GAP_W'(1) : w_gap - GAP_W'(1);
  assign w_pkt1   = r_pkt + REP_W'(1);
  assign w_last   = (w_rep != '0) && (w_pkt1 == w_rep);

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_cmd    = r_cmd;
    w_nxt_sgen   = r_sgen;
    w_nxt_accrst = 1'b0;
    w_nxt_done   = 1'b0;
    w_nxt_err    = 1'b0;
    w_nxt_ecode  = r_ecode;
    w_nxt_pkt    = r_pkt;
    w_nxt_tmo    = r_tmo;
    w_nxt_gcnt   = r_gcnt;
`ifdef DDS_SEQ_SHADOW_CMD_EN
    w_nxt_sh_v   = r_sh_v;
    w_nxt_sh     = r_sh;
`endif
    if (r_state == IDLE) begin
      if (w_acc && w_bad) begin
        w_nxt_err   = 1'b1;
        w_nxt_ecode = 2'd1;
      end else if (w_acc) begin
        w_nxt_cmd   = w_cmd;
        w_nxt_pkt   = '0;
        w_nxt_ecode = 2'd0;
        w_nxt_state = ARM;
      end
    end else begin
`ifdef DDS_SEQ_SHADOW_CMD_EN
      if (w_acc && w_bad) begin
        w_nxt_err   = 1'b1;
        w_nxt_ecode = 2'd1;
      end else if (w_acc) begin
        w_nxt_sh_v  = 1'b1;
        w_nxt_sh    = w_cmd;
        w_nxt_ecode = 2'd0;
      end
`endif
      if (ABORT) begin
        w_nxt_state  = IDLE;
        w_nxt_sgen   = 1'b0;
        w_nxt_accrst = 1'b1;
        w_nxt_err    = 1'b0;
        w_nxt_ecode  = r_ecode;
`ifdef DDS_SEQ_SHADOW_CMD_EN
        w_nxt_sh_v   = 1'b0;
`endif
      end else begin
        unique case (r_state)
          ARM: begin
            if (OUT_REG_READY) begin
              w_nxt_state = START;
              w_nxt_sgen  = 1'b1;
              w_nxt_tmo   = '0;
            end
          end
          START: begin
            if (SIGN_START_CALC) begin
              w_nxt_sgen  = 1'b0;
              w_nxt_state = RUN;
            end else if (r_tmo == TW'(START_TMO - 1)) begin
              w_nxt_sgen   = 1'b0;
              w_nxt_accrst = 1'b1;
              w_nxt_err    = 1'b1;
              w_nxt_ecode  = 2'd2;
              w_nxt_state  = IDLE;
`ifdef DDS_SEQ_SHADOW_CMD_EN
              w_nxt_sh_v   = 1'b0;
`endif
            end else begin
              w_nxt_tmo = r_tmo + TW'(1);
            end
          end
          RUN: begin
            if (SIGN_STOP_CALC) begin
              w_nxt_pkt  = w_pkt1;
              w_nxt_gcnt = w_gap_ld;
              if (w_last) begin
                w_nxt_done  = 1'b1;
                w_nxt_state = IDLE;
`ifdef DDS_SEQ_SHADOW_CMD_EN
                if (w_nxt_sh_v) begin
                  w_nxt_cmd   = w_nxt_sh;
                  w_nxt_sh_v  = 1'b0;
                  w_nxt_pkt   = '0;
                  w_nxt_state = GAP;
                end
`endif
              end else begin
                w_nxt_state = GAP;
              end
            end
          end
          GAP: begin
            if (r_gcnt == '0) w_nxt_state = ARM;
            else w_nxt_gcnt = r_gcnt - GAP_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= IDLE;
      r_cmd    <= '0;
      r_live   <= 1'b0;
      r_sgen   <= 1'b0;
      r_accrst <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_ecode  <= '0;
      r_pkt    <= '0;
      r_tmo    <= '0;
      r_gcnt   <= '0;
`ifdef DDS_SEQ_SHADOW_CMD_EN
      r_sh_v   <= 1'b0;
      r_sh     <= '0;
`endif
    end else begin
      r_state  <= w_nxt_state;
      r_cmd    <= w_nxt_cmd;
      r_live   <= 1'b1;
      r_sgen   <= w_nxt_sgen;
      r_accrst <= w_nxt_accrst;
      r_done   <= w_nxt_done;
      r_err    <= w_nxt_err;
      r_ecode  <= w_nxt_ecode;
      r_pkt    <= w_nxt_pkt;
      r_tmo    <= w_nxt_tmo;
      r_gcnt   <= w_nxt_gcnt;
`ifdef DDS_SEQ_SHADOW_CMD_EN
      r_sh_v   <= w_nxt_sh_v;
      r_sh     <= w_nxt_sh;
`endif
    end
  end

  assign SIGNAL_TYPE    = r_cmd[B+82 +: 2];
  assign F_CARRIER      = r_cmd[B+50 +: 32];
  assign T_IMPULSE      = r_cmd[B+40 +: 10];
  assign T_PERIOD       = r_cmd[B+27 +: 13];
  assign NUM_OF_IMP     = r_cmd[B+22 +: 5];
  assign DEVIATION      = r_cmd[B +: 22];
  assign SIGN_START_GEN = r_sgen;
  assign ACC_RESET      = r_accrst;
  assign BUSY           = (r_state != IDLE);
  assign DONE           = r_done;
  assign ERROR          = r_err;
  assign ERR_CODE       = r_ecode;
  assign PKT_CNT        = r_pkt;

endmodule

// File: tb/tb_dds_gen_sequencer.sv
// Scoreboard bench for dds_gen_sequencer with a behavioural accumulator model.
module tb_dds_gen_sequencer;
  logic        CLK = 0, RESET = 1, CMD_VALID = 0, CMD_READY;
  logic [1:0]  CMD_SIGNAL_TYPE = 0;
  logic [31:0] CMD_F_CARRIER = 0;
  logic [9:0]  CMD_T_IMPULSE = 0;
  logic [12:0] CMD_T_PERIOD = 0;
  logic [4:0]  CMD_NUM_OF_IMP = 0;
  logic [21:0] CMD_DEVIATION = 0;
  logic [7:0]  CMD_REPEAT = 0;
  logic [15:0] CMD_GAP = 0;
  logic        ABORT = 0, OUT_REG_READY = 0;
  logic        SIGN_START_CALC = 0, SIGN_STOP_CALC = 0;
  logic [1:0]  SIGNAL_TYPE, ERR_CODE;
  logic [31:0] F_CARRIER;
  logic [9:0]  T_IMPULSE;
  logic [12:0] T_PERIOD;
  logic [4:0]  NUM_OF_IMP;
  logic [21:0] DEVIATION;
  logic        SIGN_START_GEN, ACC_RESET, BUSY, DONE, ERROR;
  logic [7:0]  PKT_CNT;

  int n_cmp = 0, n_bad = 0;
  int q_pkt[$];
  int q_err[$];
  logic [31:0] exp_fc = 0;

  dds_gen_sequencer dut (
    .CLK(CLK), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_SIGNAL_TYPE(CMD_SIGNAL_TYPE), .CMD_F_CARRIER(CMD_F_CARRIER),
    .CMD_T_IMPULSE(CMD_T_IMPULSE), .CMD_T_PERIOD(CMD_T_PERIOD),
    .CMD_NUM_OF_IMP(CMD_NUM_OF_IMP), .CMD_DEVIATION(CMD_DEVIATION),
    .CMD_REPEAT(CMD_REPEAT), .CMD_GAP(CMD_GAP), .ABORT(ABORT),
    .OUT_REG_READY(OUT_REG_READY), .SIGN_START_CALC(SIGN_START_CALC),
    .SIGN_STOP_CALC(SIGN_STOP_CALC), .SIGNAL_TYPE(SIGNAL_TYPE),
    .F_CARRIER(F_CARRIER), .T_IMPULSE(T_IMPULSE), .T_PERIOD(T_PERIOD),
    .NUM_OF_IMP(NUM_OF_IMP), .DEVIATION(DEVIATION),
    .SIGN_START_GEN(SIGN_START_GEN), .ACC_RESET(ACC_RESET), .BUSY(BUSY),
    .DONE(DONE), .ERROR(ERROR), .ERR_CODE(ERR_CODE), .PKT_CNT(PKT_CNT)
  );

  always #5 CLK = ~CLK;

  // Accumulator model: START_CALC right after START_GEN, STOP_CALC 100 cycles later
  logic m_en = 1;
  int   m_st = 0, m_cnt = 0;
  always begin
    @(posedge CLK); #1;
    if (RESET || ACC_RESET || !m_en) begin
      SIGN_START_CALC = 0; SIGN_STOP_CALC = 0; m_st = 0;
    end else begin
      case (m_st)
        0: if (SIGN_START_GEN) begin SIGN_START_CALC = 1; m_st = 1; m_cnt = 0; end
        1: begin
          SIGN_START_CALC = 0; m_cnt++;
          if (m_cnt == 100) begin SIGN_STOP_CALC = 1; m_st = 2; end
        end
        default: begin SIGN_STOP_CALC = 0; m_st = 0; end
      endcase
    end
  end

  task automatic send_cmd(input logic [1:0] t, input logic [31:0] fc,
                          input logic [9:0] ti, input logic [12:0] tp,
                          input logic [4:0] ni, input logic [21:0] dv,
                          input logic [7:0] rp, input logic [15:0] gp);
    bit ok = 0;
    @(negedge CLK);
    CMD_SIGNAL_TYPE = t; CMD_F_CARRIER = fc; CMD_T_IMPULSE = ti;
    CMD_T_PERIOD = tp; CMD_NUM_OF_IMP = ni; CMD_DEVIATION = dv;
    CMD_REPEAT = rp; CMD_GAP = gp; CMD_VALID = 1;
    for (int i = 0; i < 400 && !ok; i++) begin
      ok = CMD_READY;
      @(posedge CLK);
    end
    @(negedge CLK);
    CMD_VALID = 0;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL send_cmd: CMD_READY=%b, required 1 within 400 cycles", CMD_READY);
    end
  endtask

  task automatic test_reset;
    logic [127:0] v;
    RESET = 1;
    repeat (3) @(negedge CLK);
    v = {CMD_READY, BUSY, DONE, ERROR, ERR_CODE, PKT_CNT, SIGN_START_GEN, ACC_RESET,
         SIGNAL_TYPE, F_CARRIER, T_IMPULSE, T_PERIOD, NUM_OF_IMP, DEVIATION};
    n_cmp++;
    if (v !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got %h, required 0", v);
    end
    RESET = 0;
    @(negedge CLK);
    n_cmp++;
    if (CMD_READY !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: CMD_READY=%b, required 1", CMD_READY);
    end
  endtask

  task automatic test_burst;
    int cyc = 0, stop_cyc = -100, rises = 0, gap_meas = -1, dones = 0, done_cyc = 0;
    logic prev_sg = 0;
    logic [7:0] prev_pkt = 0;
    int e;
    OUT_REG_READY = 1;
    q_pkt.push_back(1); q_pkt.push_back(2);
    exp_fc = 32'd1000000;
    send_cmd(2'd1, exp_fc, 10'd10, 13'd20, 5'd3, 22'd5000, 8'd2, 16'd5);
    n_cmp++;
    if (F_CARRIER !== exp_fc || T_PERIOD !== 13'd20 || NUM_OF_IMP !== 5'd3 || BUSY !== 1'b1) begin
      n_bad++;
      $display("FAIL burst_latch: fc=%0d tp=%0d ni=%0d busy=%b, required %0d 20 3 1",
               F_CARRIER, T_PERIOD, NUM_OF_IMP, BUSY, exp_fc);
    end
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK); cyc++;
      if (SIGN_STOP_CALC) stop_cyc = cyc;
      if (SIGN_START_GEN && !prev_sg) begin
        rises++;
        if (rises == 2) gap_meas = cyc - stop_cyc;
      end
      if (PKT_CNT !== prev_pkt) begin
        e = (q_pkt.size() > 0) ? q_pkt.pop_front() : -1;
        n_cmp++;
        if (int'(PKT_CNT) != e) begin
          n_bad++; $display("FAIL burst_pkt_cnt: got %0d, required %0d", PKT_CNT, e);
        end
      end
      if (DONE) begin dones++; done_cyc = cyc; end
      prev_sg = SIGN_START_GEN; prev_pkt = PKT_CNT;
      if (dones > 0 && cyc > done_cyc + 3) break;
    end
    n_cmp++;
    if (rises != 2 || dones != 1) begin
      n_bad++; $display("FAIL burst_counts: rises=%0d dones=%0d, required 2 1", rises, dones);
    end
    // 5 GAP cycles + 1 ARM cycle + 1 sampling offset
    n_cmp++;
    if (gap_meas != 7) begin
      n_bad++; $display("FAIL burst_gap: got %0d, required 7", gap_meas);
    end
    n_cmp++;
    if (BUSY !== 1'b0 || q_pkt.size() != 0) begin
      n_bad++; $display("FAIL burst_end: busy=%b left=%0d, required 0 0", BUSY, q_pkt.size());
    end
  endtask

  task automatic test_invalid;
    logic [9:0] ti[2] = '{10'd10, 10'd30};
    logic [4:0] ni[2] = '{5'd0, 5'd2};
    int e, errs;
    logic sg;
    for (int k = 0; k < 2; k++) begin
      q_err.push_back(1);
      send_cmd(2'd2, 32'd777, ti[k], 13'd20, ni[k], 22'd1, 8'd1, 16'd0);
      e = q_err.pop_front();
      n_cmp++;
      if (ERROR !== 1'b1 || int'(ERR_CODE) != e || BUSY !== 1'b0 || F_CARRIER !== exp_fc) begin
        n_bad++;
        $display("FAIL invalid_%0d: err=%b code=%0d busy=%b fc=%0d, required 1 %0d 0 %0d",
                 k, ERROR, ERR_CODE, BUSY, F_CARRIER, e, exp_fc);
      end
      errs = 0; sg = 0;
      repeat (10) begin
        @(negedge CLK);
        sg |= SIGN_START_GEN;
        if (ERROR || BUSY) errs++;
      end
      n_cmp++;
      if (sg !== 1'b0 || errs != 0) begin
        n_bad++; $display("FAIL invalid_quiet_%0d: sg=%b extra=%0d, required 0 0", k, sg, errs);
      end
    end
  endtask

  task automatic test_arm_wait;
    int bad_cyc = 0;
    bit done_seen = 0;
    OUT_REG_READY = 0;
    exp_fc = 32'd3000000;
    send_cmd(2'd0, exp_fc, 10'd5, 13'd8, 5'd1, 22'd0, 8'd1, 16'd0);
    n_cmp++;
    if (ERR_CODE !== 2'd0) begin
      n_bad++; $display("FAIL arm_errcode: got %0d, required 0", ERR_CODE);
    end
    repeat (50) begin
      @(negedge CLK);
      if (SIGN_START_GEN !== 1'b0 || BUSY !== 1'b1) bad_cyc++;
    end
    n_cmp++;
    if (bad_cyc != 0) begin
      n_bad++; $display("FAIL arm_hold: bad cycles %0d, required 0", bad_cyc);
    end
    OUT_REG_READY = 1;
    @(negedge CLK);
    n_cmp++;
    if (SIGN_START_GEN !== 1'b1) begin
      n_bad++; $display("FAIL arm_release: sg=%b, required 1", SIGN_START_GEN);
    end
    for (int i = 0; i < 300 && !done_seen; i++) begin
      @(negedge CLK);
      if (DONE) done_seen = 1;
    end
    n_cmp++;
    if (!done_seen || PKT_CNT !== 8'd1 || F_CARRIER !== exp_fc) begin
      n_bad++;
      $display("FAIL arm_done: done=%b pkt=%0d fc=%0d, required 1 1 %0d",
               done_seen, PKT_CNT, F_CARRIER, exp_fc);
    end
  endtask

  task automatic test_timeout;
    int hi = 0;
    bit fell = 0;
    m_en = 0;
    OUT_REG_READY = 1;
    exp_fc = 32'd5;
    send_cmd(2'd1, exp_fc, 10'd4, 13'd4, 5'd1, 22'd0, 8'd1, 16'd0);
    for (int i = 0; i < 200 && !fell; i++) begin
      @(negedge CLK);
      if (SIGN_START_GEN) hi++;
      else if (hi > 0) fell = 1;
    end
    n_cmp++;
    if (!fell || hi != 64) begin
      n_bad++; $display("FAIL tmo_width: high %0d cycles fell=%b, required 64 1", hi, fell);
    end
    n_cmp++;
    if (ACC_RESET !== 1'b1 || ERROR !== 1'b1 || ERR_CODE !== 2'd2 || BUSY !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_pulse: accrst=%b err=%b code=%0d busy=%b, required 1 1 2 0",
               ACC_RESET, ERROR, ERR_CODE, BUSY);
    end
    @(negedge CLK);
    n_cmp++;
    if (ACC_RESET !== 1'b0 || ERROR !== 1'b0 || ERR_CODE !== 2'd2) begin
      n_bad++;
      $display("FAIL tmo_after: accrst=%b err=%b code=%0d, required 0 0 2",
               ACC_RESET, ERROR, ERR_CODE);
    end
    m_en = 1;
  endtask

  task automatic test_abort_endless;
    int cyc = 0, stop_cyc = -100, rises = 0, gap_meas = -1, dones = 0, r3 = 0, e;
    logic prev_sg = 0;
    logic [7:0] prev_pkt = 0;
    OUT_REG_READY = 1;
    exp_fc = 32'd4000000;
    q_pkt.push_back(1); q_pkt.push_back(2);
    send_cmd(2'd3, exp_fc, 10'd10, 13'd20, 5'd2, 22'd7, 8'd0, 16'd0);
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK); cyc++;
      if (SIGN_STOP_CALC) stop_cyc = cyc;
      if (SIGN_START_GEN && !prev_sg) begin
        rises++;
        if (rises == 2) gap_meas = cyc - stop_cyc;
        if (rises == 3) r3 = cyc;
      end
      if (PKT_CNT !== prev_pkt) begin
        e = (q_pkt.size() > 0) ? q_pkt.pop_front() : -1;
        n_cmp++;
        if (int'(PKT_CNT) != e) begin
          n_bad++; $display("FAIL endless_pkt_cnt: got %0d, required %0d", PKT_CNT, e);
        end
      end
      if (DONE) dones++;
      prev_sg = SIGN_START_GEN; prev_pkt = PKT_CNT;
      if (rises == 3 && cyc == r3 + 20) break;
    end
    n_cmp++;
    if (rises != 3 || gap_meas != 4) begin
      n_bad++; $display("FAIL endless_gap: rises=%0d gap=%0d, required 3 4", rises, gap_meas);
    end
    ABORT = 1;
    @(negedge CLK);
    ABORT = 0;
    n_cmp++;
    if (ACC_RESET !== 1'b1 || BUSY !== 1'b0 || SIGN_START_GEN !== 1'b0 || PKT_CNT !== 8'd2 ||
        CMD_READY !== 1'b1 || DONE !== 1'b0 || ERROR !== 1'b0 || F_CARRIER !== exp_fc) begin
      n_bad++;
      $display("FAIL abort_state: accrst=%b busy=%b sg=%b pkt=%0d rdy=%b done=%b err=%b fc=%0d, required 1 0 0 2 1 0 0 %0d",
               ACC_RESET, BUSY, SIGN_START_GEN, PKT_CNT, CMD_READY, DONE, ERROR, F_CARRIER, exp_fc);
    end
    @(negedge CLK);
    n_cmp++;
    if (ACC_RESET !== 1'b0 || dones != 0 || DONE !== 1'b0) begin
      n_bad++; $display("FAIL abort_after: accrst=%b dones=%0d, required 0 0", ACC_RESET, dones);
    end
  endtask

  task automatic test_reset_mid;
    send_cmd(2'd1, 32'd9, 10'd3, 13'd5, 5'd2, 22'd2, 8'd1, 16'd0);
    repeat (30) @(negedge CLK);
    RESET = 1;
    @(negedge CLK);
    n_cmp++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || ERROR !== 1'b0 || F_CARRIER !== 32'd0 ||
        SIGN_START_GEN !== 1'b0 || CMD_READY !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: busy=%b done=%b err=%b fc=%0d sg=%b rdy=%b, required all 0",
               BUSY, DONE, ERROR, F_CARRIER, SIGN_START_GEN, CMD_READY);
    end
    RESET = 0;
    @(negedge CLK);
    n_cmp++;
    if (CMD_READY !== 1'b1) begin
      n_bad++; $display("FAIL reset_mid_ready: CMD_READY=%b, required 1", CMD_READY);
    end
  endtask

`ifdef DDS_SEQ_SHADOW_CMD_EN
  task automatic test_shadow;
    int dones = 0;
    bit fell = 0, early = 0;
    OUT_REG_READY = 1;
    send_cmd(2'd1, 32'd1000000, 10'd10, 13'd20, 5'd3, 22'd1, 8'd1, 16'd3);
    repeat (20) @(negedge CLK);
    send_cmd(2'd1, 32'd2000000, 10'd10, 13'd20, 5'd3, 22'd1, 8'd1, 16'd3);
    n_cmp++;
    if (CMD_READY !== 1'b0 || F_CARRIER !== 32'd1000000) begin
      n_bad++; $display("FAIL shadow_accept: rdy=%b fc=%0d, required 0 1000000", CMD_READY, F_CARRIER);
    end
    for (int i = 0; i < 600 && dones < 2; i++) begin
      @(negedge CLK);
      if (DONE) dones++;
      if (dones == 0 && F_CARRIER !== 32'd1000000) early = 1;
      if (dones < 2 && !BUSY) fell = 1;
    end
    n_cmp++;
    if (dones != 2 || fell || early || F_CARRIER !== 32'd2000000) begin
      n_bad++;
      $display("FAIL shadow_chain: dones=%0d busy_fell=%b early=%b fc=%0d, required 2 0 0 2000000",
               dones, fell, early, F_CARRIER);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_burst();
    test_invalid();
    test_arm_wait();
    test_timeout();
    test_abort_endless();
`ifdef DDS_SEQ_SHADOW_CMD_EN
    test_shadow();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
